// File: rtl/xge_wb_status_regs_pkg.sv
// Shared constants and types for the MAC host status/config register block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: register byte addresses, interrupt bit positions, interrupt
// vector type and the Wishbone ack FSM state encoding.
package xge_wb_regs_pkg;

   localparam int NUM_INT = 9;

   // Register byte addresses; only bits [7:2] take part in decode.
   localparam logic [7:0] ADDR_CONFIG      = 8'h00;
   localparam logic [7:0] ADDR_INT_PENDING = 8'h08;
   localparam logic [7:0] ADDR_INT_STATUS  = 8'h0C;
   localparam logic [7:0] ADDR_INT_MASK    = 8'h10;
   localparam logic [7:0] ADDR_CRC_CNT     = 8'h20;
   localparam logic [7:0] ADDR_FRAG_CNT    = 8'h24;

   // Bit positions, identical in INT_PENDING, INT_STATUS and INT_MASK.
   localparam int INT_TXDFIFO_OVFLOW = 0;
   localparam int INT_TXDFIFO_UDFLOW = 1;
   localparam int INT_RXDFIFO_OVFLOW = 2;
   localparam int INT_RXDFIFO_UDFLOW = 3;
   localparam int INT_LOCAL_FAULT    = 4;
   localparam int INT_REMOTE_FAULT   = 5;
   localparam int INT_PAUSE_FRAME_RX = 6;
   localparam int INT_CRC_ERROR      = 7;
   localparam int INT_FRAGMENT_ERROR = 8;

   typedef logic [NUM_INT-1:0] int_vec_t;

   // Ack FSM: plain logic encoding so the state can be probed by legacy tools.
   typedef logic [0:0] ack_state_t;
   localparam ack_state_t ST_IDLE = 1'b0;
   localparam ack_state_t ST_ACK  = 1'b1;

endpackage

// File: rtl/xge_wb_status_regs_if.sv
// Wishbone B3 classic bus bundle between host and status register block.
// Latency: n/a (wires only).
// Backpressure: slave acks each accepted strobe exactly one cycle later.
// Ports: adr/dat_i/we/stb/cyc driven by the master; dat_o/ack by the slave.
interface xge_wb_status_regs_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] wb_adr_i;
   logic [DATA_W-1:0] wb_dat_i;
   logic              wb_we_i;
   logic              wb_stb_i;
   logic              wb_cyc_i;
   logic [DATA_W-1:0] wb_dat_o;
   logic              wb_ack_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/xge_wb_status_regs_sat_counter.sv
// 32-bit saturating event counter with synchronous clear.
// Latency: count visible one cycle after the increment pulse.
// Backpressure: none; an increment coinciding with clear leaves the count at 1.
// Ports: clk_i/rst_i (async active-high), inc_i, clr_i, cnt_o.
module xge_sat_counter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   input  logic        clr_i,
   output logic [31:0] cnt_o
);
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         // Clearing must not swallow an event arriving in the same cycle.
         cnt_d = {31'b0, inc_i};
      end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/xge_wb_status_regs.sv
// Wishbone B3 slave holding MAC config, sticky interrupt and status registers.
// Latency: request sampled at edge N is acked with read data at N+1; wb_int_o
//          follows pending/mask one cycle later.
// Backpressure: one ack per two cycles; a held strobe re-accepts after a gap.
// Ports: wb_clk_i/wb_rst_i (async active-high), wb (slave modport), status_*
//        event/fault inputs, wb_int_o level interrupt, ctrl_tx_enable.
// Build option: define XGE_WB_STAT_COUNTERS_EN to add CRC/fragment counters
//        at 0x20/0x24; without it those addresses read 0.
module xge_wb_status_regs
   import xge_wb_regs_pkg::*;
#(
   parameter int   ADDR_W    = 8,
   parameter int   DATA_W    = 32,
   parameter logic TX_EN_RST = 1'b1
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   xge_wb_status_regs_if.slave wb,
   input  logic                status_crc_error,
   input  logic                status_fragment_error,
   input  logic                status_txdfifo_ovflow,
   input  logic                status_txdfifo_udflow,
   input  logic                status_rxdfifo_ovflow,
   input  logic                status_rxdfifo_udflow,
   input  logic                status_pause_frame_rx,
   input  logic                status_local_fault,
   input  logic                status_remote_fault,
   output logic                wb_int_o,
   output logic                ctrl_tx_enable
);
   ack_state_t        state_q, state_d;
   logic [ADDR_W-1:2] adr_q;
   logic              we_q;
   int_vec_t          wdat_q;
   logic [DATA_W-1:0] rdat_q;
   logic [DATA_W-1:0] rd_mux;
   logic              tx_en_q;
   int_vec_t          mask_q;
   int_vec_t          pend_q, pend_d;
   logic [1:0]        fault_hist_q;
   int_vec_t          live_vec, event_vec;
   logic              int_q;
   logic              accept, ack_cyc, wr_commit, rd_commit;
   logic [5:0]        cur_word, ack_word;
   logic              unused_bits;

   assign accept    = (state_q == ST_IDLE) & wb.wb_cyc_i & wb.wb_stb_i;
   assign ack_cyc   = (state_q == ST_ACK);
   // ACK always falls back to IDLE, which forces the gap between acks.
   assign state_d   = accept ? ST_ACK : ST_IDLE;
   assign wr_commit = ack_cyc & we_q;
   assign rd_commit = ack_cyc & ~we_q;
   assign cur_word  = wb.wb_adr_i[7:2];
   assign ack_word  = adr_q[7:2];

   always_comb begin
      live_vec = '0;
      live_vec[INT_TXDFIFO_OVFLOW] = status_txdfifo_ovflow;
      live_vec[INT_TXDFIFO_UDFLOW] = status_txdfifo_udflow;
      live_vec[INT_RXDFIFO_OVFLOW] = status_rxdfifo_ovflow;
      live_vec[INT_RXDFIFO_UDFLOW] = status_rxdfifo_udflow;
      live_vec[INT_LOCAL_FAULT]    = status_local_fault;
      live_vec[INT_REMOTE_FAULT]   = status_remote_fault;
      live_vec[INT_PAUSE_FRAME_RX] = status_pause_frame_rx;
      live_vec[INT_CRC_ERROR]      = status_crc_error;
      live_vec[INT_FRAGMENT_ERROR] = status_fragment_error;
      // Fault levels interrupt on either edge, not on the level itself.
      event_vec = live_vec;
      event_vec[INT_LOCAL_FAULT]  = status_local_fault  ^ fault_hist_q[0];
      event_vec[INT_REMOTE_FAULT] = status_remote_fault ^ fault_hist_q[1];
   end

`ifdef XGE_WB_STAT_COUNTERS_EN
   logic [31:0] crc_cnt, frag_cnt;
   logic        crc_clr, frag_clr;

   assign crc_clr  = rd_commit & (ack_word == ADDR_CRC_CNT[7:2]);
   assign frag_clr = rd_commit & (ack_word == ADDR_FRAG_CNT[7:2]);

   xge_sat_counter u_crc_cnt (
      .clk_i (wb_clk_i),
      .rst_i (wb_rst_i),
      .inc_i (status_crc_error),
      .clr_i (crc_clr),
      .cnt_o (crc_cnt)
   );

   xge_sat_counter u_frag_cnt (
      .clk_i (wb_clk_i),
      .rst_i (wb_rst_i),
      .inc_i (status_fragment_error),
      .clr_i (frag_clr),
      .cnt_o (frag_cnt)
   );
`endif

   always_comb begin
      rd_mux = '0;
      case (cur_word)
         ADDR_CONFIG[7:2]:      rd_mux[0]           = tx_en_q;
         ADDR_INT_PENDING[7:2]: rd_mux[NUM_INT-1:0] = pend_q;
         ADDR_INT_STATUS[7:2]:  rd_mux[NUM_INT-1:0] = live_vec;
         ADDR_INT_MASK[7:2]:    rd_mux[NUM_INT-1:0] = mask_q;
`ifdef XGE_WB_STAT_COUNTERS_EN
         ADDR_CRC_CNT[7:2]:     rd_mux              = crc_cnt;
         ADDR_FRAG_CNT[7:2]:    rd_mux              = frag_cnt;
`endif
         default:               rd_mux              = '0;
      endcase
   end

   // Read-clear only drops bits that were in the returned snapshot; anything
   // raised since, including this cycle, stays pending.
   always_comb begin
      pend_d = pend_q;
      if (rd_commit && (ack_word == ADDR_INT_PENDING[7:2])) begin
         pend_d = pend_q & ~rdat_q[NUM_INT-1:0];
      end
      pend_d = pend_d | event_vec;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= ST_IDLE;
         adr_q        <= '0;
         we_q         <= 1'b0;
         wdat_q       <= '0;
         rdat_q       <= '0;
         tx_en_q      <= TX_EN_RST;
         mask_q       <= '0;
         pend_q       <= '0;
         fault_hist_q <= '0;
         int_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            adr_q  <= wb.wb_adr_i[ADDR_W-1:2];
            we_q   <= wb.wb_we_i;
            wdat_q <= wb.wb_dat_i[NUM_INT-1:0];
            rdat_q <= rd_mux;
         end
         if (wr_commit && (ack_word == ADDR_CONFIG[7:2]))   tx_en_q <= wdat_q[0];
         if (wr_commit && (ack_word == ADDR_INT_MASK[7:2])) mask_q  <= wdat_q;
         pend_q       <= pend_d;
         fault_hist_q <= {status_remote_fault, status_local_fault};
         int_q        <= |(pend_q & mask_q);
      end
   end

   assign wb.wb_ack_o    = ack_cyc;
   assign wb.wb_dat_o    = ack_cyc ? rdat_q : '0;
   assign wb_int_o       = int_q;
   assign ctrl_tx_enable = tx_en_q;

   // Byte lanes and upper write-data bits carry no register state.
   assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_dat_i[DATA_W-1:NUM_INT]};
endmodule

// File: tb/tb_xge_wb_status_regs.sv
// Self-checking bench for the MAC status/config Wishbone register block.
// Latency: n/a.
// Backpressure: n/a.
module tb_xge_wb_status_regs;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic status_crc_error = 1'b0, status_fragment_error = 1'b0;
   logic status_txdfifo_ovflow = 1'b0, status_txdfifo_udflow = 1'b0;
   logic status_rxdfifo_ovflow = 1'b0, status_rxdfifo_udflow = 1'b0;
   logic status_pause_frame_rx = 1'b0;
   logic status_local_fault = 1'b0, status_remote_fault = 1'b0;
   logic wb_int_o, ctrl_tx_enable;

   xge_wb_status_regs_if #(.ADDR_W(8), .DATA_W(32)) wb_if ();

   xge_wb_status_regs #(.ADDR_W(8), .DATA_W(32), .TX_EN_RST(1'b1)) dut (
      .wb_clk_i              (clk),
      .wb_rst_i              (rst),
      .wb                    (wb_if),
      .status_crc_error      (status_crc_error),
      .status_fragment_error (status_fragment_error),
      .status_txdfifo_ovflow (status_txdfifo_ovflow),
      .status_txdfifo_udflow (status_txdfifo_udflow),
      .status_rxdfifo_ovflow (status_rxdfifo_ovflow),
      .status_rxdfifo_udflow (status_rxdfifo_udflow),
      .status_pause_frame_rx (status_pause_frame_rx),
      .status_local_fault    (status_local_fault),
      .status_remote_fault   (status_remote_fault),
      .wb_int_o              (wb_int_o),
      .ctrl_tx_enable        (ctrl_tx_enable)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Called #1 after a clock edge with the slave idle; returns #1 after the
   // edge that ends the ack cycle.
   task automatic bus(input logic we, input logic [7:0] adr, input logic [31:0] wdat,
                      output logic [31:0] rdat);
      wb_if.wb_cyc_i = 1'b1;
      wb_if.wb_stb_i = 1'b1;
      wb_if.wb_we_i  = we;
      wb_if.wb_adr_i = adr;
      wb_if.wb_dat_i = wdat;
      @(posedge clk); #1;
      check("ack_rise", {31'b0, wb_if.wb_ack_o}, 32'd1);
      rdat = wb_if.wb_dat_o;
      wb_if.wb_cyc_i = 1'b0;
      wb_if.wb_stb_i = 1'b0;
      wb_if.wb_we_i  = 1'b0;
      @(posedge clk); #1;
      check("ack_fall", {31'b0, wb_if.wb_ack_o}, 32'd0);
      check("dat_idle", wb_if.wb_dat_o, 32'd0);
   endtask

   task automatic rd_check(input string name, input logic [7:0] adr, input logic [31:0] exp);
      logic [31:0] r;
      bus(1'b0, adr, 32'd0, r);
      check(name, r, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        we;
      logic [7:0]  adr;
      logic [31:0] wdat;
      logic [31:0] exp_rd;
      logic        exp_txen;
   } vec_t;
   vec_t tbl [16];

   // Reference model state (register-level view of the block).
   logic        m_txen;
   logic [8:0]  m_mask, m_pend, m_ev, m_live;
   logic [1:0]  m_prev_f;
   logic        m_int, m_busy, m_we, m_req, m_clr_crc, m_clr_frag;
   logic [7:0]  m_adr;
   logic [31:0] m_wdat, m_snap, m_cand, m_crc, m_frag;
   logic [7:0]  adr_list [8];
   logic [31:0] rd;
   logic [5:0]  pat;
   int          acks;

   function automatic logic [31:0] model_read(input logic [7:0] a, input logic [8:0] live);
      case (a & 8'hFC)
         8'h00:   return {31'b0, m_txen};
         8'h08:   return {23'b0, m_pend};
         8'h0C:   return {23'b0, live};
         8'h10:   return {23'b0, m_mask};
`ifdef XGE_WB_STAT_COUNTERS_EN
         8'h20:   return m_crc;
         8'h24:   return m_frag;
`endif
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic inc);
      if (inc && c != 32'hFFFF_FFFF) return c + 32'd1;
      return c;
   endfunction

   initial begin
      wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
      wb_if.wb_adr_i = 8'h00; wb_if.wb_dat_i = 32'h0;

      tbl[0]  = '{1'b0, 8'h00, 32'h0,         32'h1,   1'b1};
      tbl[1]  = '{1'b0, 8'h08, 32'h0,         32'h0,   1'b1};
      tbl[2]  = '{1'b0, 8'h0C, 32'h0,         32'h0,   1'b1};
      tbl[3]  = '{1'b0, 8'h10, 32'h0,         32'h0,   1'b1};
      tbl[4]  = '{1'b0, 8'h3C, 32'h0,         32'h0,   1'b1};
      tbl[5]  = '{1'b0, 8'h20, 32'h0,         32'h0,   1'b1};
      tbl[6]  = '{1'b0, 8'h24, 32'h0,         32'h0,   1'b1};
      tbl[7]  = '{1'b1, 8'h00, 32'h0,         32'h0,   1'b0};
      tbl[8]  = '{1'b0, 8'h00, 32'h0,         32'h0,   1'b0};
      tbl[9]  = '{1'b1, 8'h10, 32'hFFFF_FE5A, 32'h0,   1'b0};
      tbl[10] = '{1'b0, 8'h10, 32'h0,         32'h5A,  1'b0};
      tbl[11] = '{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0,   1'b1};
      tbl[12] = '{1'b0, 8'h01, 32'h0,         32'h1,   1'b1};
      tbl[13] = '{1'b1, 8'h3C, 32'hFFFF_FFFF, 32'h0,   1'b1};
      tbl[14] = '{1'b0, 8'h12, 32'h0,         32'h5A,  1'b1};
      tbl[15] = '{1'b1, 8'h10, 32'h0,         32'h0,   1'b1};

      adr_list[0] = 8'h00; adr_list[1] = 8'h08; adr_list[2] = 8'h0C; adr_list[3] = 8'h10;
      adr_list[4] = 8'h20; adr_list[5] = 8'h24; adr_list[6] = 8'h3C; adr_list[7] = 8'h0B;

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_ack",  {31'b0, wb_if.wb_ack_o}, 32'd0);
      check("rst_dat",  wb_if.wb_dat_o, 32'd0);
      check("rst_int",  {31'b0, wb_int_o}, 32'd0);
      check("rst_txen", {31'b0, ctrl_tx_enable}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      cycles(1);

      // Register map vectors.
      for (int i = 0; i < 16; i++) begin
         bus(tbl[i].we, tbl[i].adr, tbl[i].wdat, rd);
         if (!tbl[i].we) check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
         check($sformatf("tbl%0d_txen", i), {31'b0, ctrl_tx_enable}, {31'b0, tbl[i].exp_txen});
      end

      // Pulse capture, masked interrupt, read-clear.
      bus(1'b1, 8'h10, 32'h1, rd);
      status_txdfifo_ovflow = 1'b1;
      cycles(1);
      status_txdfifo_ovflow = 1'b0;
      check("int_lag", {31'b0, wb_int_o}, 32'd0);
      cycles(1);
      check("int_set", {31'b0, wb_int_o}, 32'd1);
      rd_check("pend_rd1", 8'h08, 32'h1);
      cycles(1);
      check("int_clr", {31'b0, wb_int_o}, 32'd0);
      rd_check("pend_rd2", 8'h08, 32'h0);

      // Event on the ack cycle of a pending read is kept.
      wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b0; wb_if.wb_adr_i = 8'h08;
      @(posedge clk); #1;
      status_rxdfifo_ovflow = 1'b1;
      wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0;
      check("race_ack", {31'b0, wb_if.wb_ack_o}, 32'd1);
      check("race_rd",  wb_if.wb_dat_o, 32'd0);
      cycles(1);
      status_rxdfifo_ovflow = 1'b0;
      rd_check("race_kept", 8'h08, 32'h4);
      rd_check("race_gone", 8'h08, 32'h0);

      // Fault level: both edges latch, status tracks the level, mask 0.
      bus(1'b1, 8'h10, 32'h0, rd);
      status_local_fault = 1'b1;
      cycles(2);
      check("lf_int0", {31'b0, wb_int_o}, 32'd0);
      rd_check("lf_rise", 8'h08, 32'h10);
      rd_check("lf_live1", 8'h0C, 32'h10);
      rd_check("lf_noev", 8'h08, 32'h0);
      status_local_fault = 1'b0;
      cycles(2);
      rd_check("lf_live0", 8'h0C, 32'h0);
      rd_check("lf_fall", 8'h08, 32'h10);
      check("lf_int1", {31'b0, wb_int_o}, 32'd0);

      // Held strobe: acks on alternate cycles.
      wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_adr_i = 8'h3C;
      acks = 0;
      pat  = '0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         pat[i] = wb_if.wb_ack_o;
         if (wb_if.wb_ack_o) begin
            acks++;
            check("hold_dat", wb_if.wb_dat_o, 32'd0);
         end
      end
      wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0;
      check("hold_acks", acks, 32'd3);
      check("hold_pat", {26'b0, pat}, 32'b010101);
      cycles(1);

      // Reset during an in-flight mask write.
      wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b1;
      wb_if.wb_adr_i = 8'h10; wb_if.wb_dat_i = 32'h1FF;
      @(posedge clk); #1;
      wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
      check("mid_ack", {31'b0, wb_if.wb_ack_o}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ack", {31'b0, wb_if.wb_ack_o}, 32'd0);
      check("mid_rst_dat", wb_if.wb_dat_o, 32'd0);
      cycles(1);
      rst = 1'b0;
      cycles(1);
      rd_check("mid_discard", 8'h10, 32'h0);

`ifdef XGE_WB_STAT_COUNTERS_EN
      for (int i = 0; i < 5; i++) begin
         status_crc_error = 1'b1; cycles(1);
         status_crc_error = 1'b0; cycles(1);
      end
      rd_check("crc_5", 8'h20, 32'd5);
      rd_check("crc_clr", 8'h20, 32'd0);
      for (int i = 0; i < 2; i++) begin
         status_fragment_error = 1'b1; cycles(1);
         status_fragment_error = 1'b0; cycles(1);
      end
      rd_check("frag_2", 8'h24, 32'd2);
      wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_adr_i = 8'h20;
      @(posedge clk); #1;
      status_crc_error = 1'b1;
      wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0;
      check("crc_race_rd", wb_if.wb_dat_o, 32'd0);
      cycles(1);
      status_crc_error = 1'b0;
      rd_check("crc_race_1", 8'h20, 32'd1);
      force dut.u_crc_cnt.cnt_q = 32'hFFFF_FFFE;
      cycles(1);
      release dut.u_crc_cnt.cnt_q;
      status_crc_error = 1'b1; cycles(2);
      status_crc_error = 1'b0; cycles(1);
      rd_check("crc_sat", 8'h20, 32'hFFFF_FFFF);
`endif

      // Randomised run against the register-level model, from a fresh reset.
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      m_txen = 1'b1; m_mask = '0; m_pend = '0; m_prev_f = '0; m_int = 1'b0;
      m_busy = 1'b0; m_we = 1'b0; m_adr = '0; m_wdat = '0; m_snap = '0;
      m_crc = '0; m_frag = '0;
      for (int c = 0; c < 400; c++) begin
         status_txdfifo_ovflow = ($urandom_range(0, 3) == 0);
         status_txdfifo_udflow = ($urandom_range(0, 3) == 0);
         status_rxdfifo_ovflow = ($urandom_range(0, 3) == 0);
         status_rxdfifo_udflow = ($urandom_range(0, 3) == 0);
         status_pause_frame_rx = ($urandom_range(0, 3) == 0);
         status_crc_error      = ($urandom_range(0, 3) == 0);
         status_fragment_error = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) status_local_fault  = ~status_local_fault;
         if ($urandom_range(0, 7) == 0) status_remote_fault = ~status_remote_fault;
         m_req = ($urandom_range(0, 1) == 1);
         wb_if.wb_cyc_i = m_req;
         wb_if.wb_stb_i = m_req;
         wb_if.wb_we_i  = ($urandom_range(0, 2) == 0);
         wb_if.wb_adr_i = adr_list[$urandom_range(0, 7)];
         wb_if.wb_dat_i = $urandom;
         m_live = {status_fragment_error, status_crc_error, status_pause_frame_rx,
                   status_remote_fault, status_local_fault, status_rxdfifo_udflow,
                   status_rxdfifo_ovflow, status_txdfifo_udflow, status_txdfifo_ovflow};
         m_cand = model_read(wb_if.wb_adr_i, m_live);
         @(posedge clk);
         m_ev    = m_live;
         m_ev[4] = (status_local_fault  != m_prev_f[0]);
         m_ev[5] = (status_remote_fault != m_prev_f[1]);
         m_int   = |(m_pend & m_mask);
         m_clr_crc  = 1'b0;
         m_clr_frag = 1'b0;
         if (m_busy) begin
            if (m_we) begin
               if ((m_adr & 8'hFC) == 8'h00) m_txen = m_wdat[0];
               if ((m_adr & 8'hFC) == 8'h10) m_mask = m_wdat[8:0];
            end else begin
               if ((m_adr & 8'hFC) == 8'h08) m_pend = m_pend & ~m_snap[8:0];
               m_clr_crc  = ((m_adr & 8'hFC) == 8'h20);
               m_clr_frag = ((m_adr & 8'hFC) == 8'h24);
            end
            m_busy = 1'b0;
         end else if (m_req) begin
            m_busy = 1'b1;
            m_snap = m_cand;
            m_we   = wb_if.wb_we_i;
            m_adr  = wb_if.wb_adr_i;
            m_wdat = wb_if.wb_dat_i;
         end
         m_crc  = m_clr_crc  ? {31'b0, status_crc_error}      : sat_inc(m_crc, status_crc_error);
         m_frag = m_clr_frag ? {31'b0, status_fragment_error} : sat_inc(m_frag, status_fragment_error);
         m_pend   = m_pend | m_ev;
         m_prev_f = {status_remote_fault, status_local_fault};
         #1;
         check("rnd_ack",  {31'b0, wb_if.wb_ack_o}, {31'b0, m_busy});
         check("rnd_dat",  wb_if.wb_dat_o, m_busy ? m_snap : 32'd0);
         check("rnd_int",  {31'b0, wb_int_o}, {31'b0, m_int});
         check("rnd_txen", {31'b0, ctrl_tx_enable}, {31'b0, m_txen});
      end
      wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
